seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit seven-segment display. One shared hex-to-seven-segment decoder serves all digits. The block walks one digit at a time, presents that digit's 4-bit nibble to the decoder, and drives a one-hot digit enable. Display values are double-buffered so that a frame never shows a mix of old and new values (no tearing). Dead cycles between digits prevent ghosting.

Parameters:
DIGITS, 4, number of digits scanned; legal range 1..8
REFRESH_DIV, 50000, clock cycles each digit stays lit; must be >= 1
DEAD_CYCLES, 2, clock cycles with all digits off before each digit slot; must be >= 1

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
value  input  4*DIGITS  packed nibbles; nibble i = value[4i+3:4i] is shown on digit i
load  input  1  one-cycle strobe; captures value into the shadow buffer
blank  input  DIGITS  per-digit force-off mask; bit i suppresses digit i
hex  output  4  nibble fed to the shared decoder (registered)
digit_en  output  DIGITS  one-hot active-high digit enable (registered)
frame_pulse  output  1  one-cycle pulse at each frame boundary (registered)

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (immediate, also mid-operation):
  - hex=0, digit_en=0, frame_pulse=0.
  - shadow=0, active=0, pending=0.
  - idx=0, cnt=0, state=DEAD.
- State machine with two states, DEAD and SHOW.
- DEAD state:
  - digit_en=0.
  - Lasts exactly DEAD_CYCLES cycles, then goes to SHOW.
  - On the DEAD->SHOW edge, digit_en <= one-hot(idx) unless blank[idx]=1; if blanked, digit_en stays 0.
  - blank is sampled only on this edge.
- SHOW state:
  - Lasts exactly REFRESH_DIV cycles.
  - Then idx <= (idx==DIGITS-1) ? 0 : idx+1, state goes to DEAD, digit_en <= 0.
- hex is updated on entry to DEAD to the nibble of the next digit, giving the decoder DEAD_CYCLES cycles to settle. After reset, hex = active nibble 0 = 0.
- Digit order: 0, 1, ..., DIGITS-1, then wrap to 0.
- Frame period: DIGITS*(REFRESH_DIV+DEAD_CYCLES) cycles.
- The first lit slot is digit 0, at cycle DEAD_CYCLES after reset release.
- Frame boundary = the SHOW->DEAD transition with idx==DIGITS-1. At this edge:
  - frame_pulse=1 for one cycle.
  - If pending: active <= shadow, pending <= 0.
  - hex takes nibble 0 of the newly committed active value.
- load: shadow <= value, pending <= 1. A later load before the boundary overwrites shadow (last load wins).
- load on the same cycle as the frame boundary: value bypasses shadow and is committed to active directly; pending ends at 0.
- Counter width is $clog2(max(REFRESH_DIV, DEAD_CYCLES)+1). The counter reloads at each state change and never free-runs across states.
- Changing blank mid-slot has no effect until the next DEAD->SHOW edge.

Optional Feature:
Macro SEG7_SCAN_LEADING_ZERO_BLANK_EN.
- Defined: digit i (i>0) is also blanked when nibble i and every higher nibble of active are 0. Digit 0 is never blanked by this rule. The effect is ORed with blank and applied at the same DEAD->SHOW edge; slot timing is unchanged.
- Undefined: only blank suppresses digits; no extra logic is synthesised.

Test Plan:
All scenarios use DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.
1. Reset then release -> during reset all outputs 0. First digit_en=0001 one cycle after release, with hex=0. frame_pulse first rises 20 cycles after release.
2. load=1 with value=16'h1234 during frame 0 -> the frame after the boundary shows hex 4,3,2,1 on digit_en 0001,0010,0100,1000. Each digit is lit 4 cycles, with 1 all-off cycle between digits.
3. load 16'h1234, wait a full frame, then load 16'hABCD while digit 1 is lit -> digits 2,3 still show 2,1. The next frame shows D,C,B,A.
4. blank=4'b0100 with value 16'h1234 -> slot 2 has digit_en=0000 for 4 cycles. Slots 0,1,3 are unchanged and the frame period stays 20.
5. rst_n low in the middle of a SHOW slot -> digit_en=0 and hex=0 immediately, without waiting for a clock edge. After release the scan restarts at digit 0 showing 0.
6. With SEG7_SCAN_LEADING_ZERO_BLANK_EN and 16'h0050 committed -> digits 3,2 are dark; digit 1 shows 5 and digit 0 shows 0. With 16'h0000, only digit 0 lights.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// One shared hex-to-seven-segment decoder serves every digit: the block walks
// the digits in order 0..DIGITS-1, presents the current digit's nibble on
// `hex` and lights exactly one digit through `digit_en`.
//
// Each digit slot is DEAD_CYCLES all-off cycles followed by REFRESH_DIV lit
// cycles. The all-off gap lets the decoder settle on the next nibble before
// the next digit lights, which prevents ghosting.
//
// Display values are double-buffered. `load` captures `value` into a shadow
// buffer, and the shadow is committed to the active buffer only at a frame
// boundary. A frame therefore never shows a mix of old and new digits.
//
// Optional feature (compile-time macro SEG7_SCAN_LEADING_ZERO_BLANK_EN):
//   When defined, digit i (i > 0) is also dark when nibble i and every higher
//   nibble of the active value are zero. Digit 0 is never dark by this rule.
//   When undefined, only `blank` suppresses digits and no extra logic exists.
//
// Parameters
//   DIGITS       number of digits scanned (1..8)
//   REFRESH_DIV  clock cycles each digit stays lit (>= 1)
//   DEAD_CYCLES  all-off clock cycles before each digit slot (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   value        packed nibbles; nibble i = value[4i+3:4i] drives digit i
//   load         one-cycle strobe; captures value for the next frame
//   blank        per-digit force-off mask, sampled when a slot lights
//   hex          nibble for the shared decoder (registered)
//   digit_en     one-hot active-high digit enable (registered)
//   frame_pulse  one-cycle pulse at each frame boundary (registered)
// ----------------------------------------------------------------------------
module seg7_scan_ctrl #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4*DIGITS-1:0] value,
   input  logic                load,
   input  logic [DIGITS-1:0]   blank,
   output logic [3:0]          hex,
   output logic [DIGITS-1:0]   digit_en,
   output logic                frame_pulse
);

   // -------------------------------------------------------------------------
   // Derived constants
   // -------------------------------------------------------------------------
   localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] EN_ONE    = DIGITS'(1);

   typedef enum logic {
      ST_DEAD = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   // -------------------------------------------------------------------------
   // Declarations
   // -------------------------------------------------------------------------
   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_to_show;
   logic                w_to_dead;
   logic                w_boundary;

   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_idx_nxt;

   logic [4*DIGITS-1:0] r_shadow;
   logic [4*DIGITS-1:0] r_active;
   logic                r_pending;
   logic [4*DIGITS-1:0] w_commit_val;
   logic [3:0]          w_act_nib [DIGITS];

   logic [DIGITS-1:0]   w_blank_eff;
   logic                w_slot_dark;

   logic [3:0]          r_hex;
   logic [DIGITS-1:0]   r_digit_en;
   logic                r_frame_pulse;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: every clocked block uses non-blocking assignments, so all registers
   // update together from pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_DEAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and transition strobes
   // -------------------------------------------------------------------------
   // NOTE: every output of a combinational block gets a default first, so no
   // path through it can leave a value unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_to_show   = 1'b0;
      w_to_dead   = 1'b0;
      case (r_state)
         ST_DEAD: begin
            if (r_cnt == DEAD_LAST) begin
               w_state_nxt = ST_SHOW;
               w_to_show   = 1'b1;
            end
         end
         ST_SHOW: begin
            if (r_cnt == SHOW_LAST) begin
               w_state_nxt = ST_DEAD;
               w_to_dead   = 1'b1;
            end
         end
      endcase
   end

   // The last digit's slot ending is the frame boundary.
   assign w_boundary = w_to_dead && (r_idx == LAST_IDX);
   assign w_idx_nxt  = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

   // -------------------------------------------------------------------------
   // Slot counter: counts cycles spent in the current state and restarts on
   // every state change, so DEAD and SHOW are timed independently.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_to_show || w_to_dead) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Digit index: advances when a lit slot ends
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (w_to_dead) begin
         r_idx <= w_idx_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Double buffer
   // -------------------------------------------------------------------------
   // Value committed at a boundary. A load on the boundary cycle itself
   // bypasses the shadow and becomes active at once. Otherwise a pending
   // shadow is promoted, or the active value is kept.
   always_comb begin
      w_commit_val = r_active;
      if (load) begin
         w_commit_val = value;
      end else if (r_pending) begin
         w_commit_val = r_shadow;
      end
   end

   // NOTE: the display buffers are ordinary flops, not a RAM, and they are
   // reset so the display shows a defined all-zero value after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow  <= '0;
         r_active  <= '0;
         r_pending <= 1'b0;
      end else if (w_boundary) begin
         r_active  <= w_commit_val;
         r_pending <= 1'b0;
      end else if (load) begin
         r_shadow  <= value;
         r_pending <= 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         w_act_nib[i] = r_active[4*i +: 4];
      end
   end

   // -------------------------------------------------------------------------
   // Per-slot suppression, evaluated when a slot is about to light
   // -------------------------------------------------------------------------
`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] w_lz_mask;
   logic              w_upper_zero;

   // Scan from the most significant digit down. A digit is a leading zero
   // while it and everything above it are zero. Digit 0 always stays lit.
   always_comb begin
      w_lz_mask    = '0;
      w_upper_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_upper_zero = w_upper_zero && (w_act_nib[i] == 4'h0);
         if (i != 0) begin
            w_lz_mask[i] = w_upper_zero;
         end
      end
   end

   assign w_blank_eff = blank | w_lz_mask;
`else
   assign w_blank_eff = blank;
`endif

   assign w_slot_dark = w_blank_eff[r_idx];

   // -------------------------------------------------------------------------
   // Registered outputs
   // -------------------------------------------------------------------------
   // hex moves to the next digit's nibble when the all-off gap starts. The
   // decoder then has the whole gap to settle before that digit lights.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hex <= 4'h0;
      end else if (w_boundary) begin
         r_hex <= w_commit_val[3:0];
      end else if (w_to_dead) begin
         r_hex <= w_act_nib[w_idx_nxt];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digit_en <= '0;
      end else if (w_to_show) begin
         r_digit_en <= w_slot_dark ? '0 : (EN_ONE << r_idx);
      end else if (w_to_dead) begin
         r_digit_en <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_pulse <= 1'b0;
      end else begin
         r_frame_pulse <= w_boundary;
      end
   end

   assign hex         = r_hex;
   assign digit_en    = r_digit_en;
   assign frame_pulse = r_frame_pulse;

endmodule
